// File: rtl/lut6_cfg_writer.sv
// Run-time reloadable 6-input LUT: a 64-bit table word is accepted on a valid/ready
// handshake and shifted MSB-first into the table while lookups stay combinational.
module lut6_cfg_writer #(
    parameter logic [63:0] INIT           = 64'h0000000000000000,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      WR_VALID,
    output logic                      WR_READY,
    input  logic [63:0]               WR_DATA,
    input  logic                      ADR0,
    input  logic                      ADR1,
    input  logic                      ADR2,
    input  logic                      ADR3,
    input  logic                      ADR4,
    input  logic                      ADR5,
    output logic                      O,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [BITS_PER_CYCLE-1:0] CDO
);

    localparam int unsigned B  = BITS_PER_CYCLE;
    localparam int unsigned N  = 64 / B;
    localparam int unsigned CW = $clog2(N + 1);

    if (!(B == 1 || B == 2 || B == 4 || B == 8)) begin : g_bad_bits_per_cycle
        $error("lut6_cfg_writer: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     tbl_q, tbl_d;
    logic [63:0]     sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // State and datapath registers; reset always restores INIT, aborting any load
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            tbl_q   <= INIT;
            sr_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tbl_q   <= tbl_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath; status flags are decoded from the next state so they are registered
    always_comb begin
        state_d = state_q;
        tbl_d   = tbl_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (WR_VALID && ready_q) begin
                    sr_d    = WR_DATA;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                tbl_d = {tbl_q[63-B:0], sr_q[63 -: B]};
                sr_d  = sr_q << B;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_SHIFT);
        done_d  = (state_d == S_DONE);
    end

    assign WR_READY = ready_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign O        = tbl_q[{ADR5, ADR4, ADR3, ADR2, ADR1, ADR0}];
    assign CDO      = tbl_q[63 -: B];

endmodule
